// File: rtl/imm_build_sequencer.sv
// imm_build_sequencer: assembles a 32-bit constant from up to four 8-bit immediate lanes,
// pushing one lane per cycle through an external 8-bit zero-extension unit and OR-ing the
// returned word into an accumulator at the lane's byte position.
// Optional feature: define IMM_SEQ_SIGN_EXT_EN to honour req_sext (sign-fill above the
// used lanes on the final build edge). Without it the result is always zero-filled.
module imm_build_sequencer #(
  parameter int unsigned LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [LANES*8-1:0]   req_bytes,
  input  logic [1:0]           req_len,
  input  logic                 req_sext,
  output logic [7:0]           zext_byte,
  input  logic [LANES*8-1:0]   zext_word,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [LANES*8-1:0]   res_data,
  output logic                 busy
);

  localparam int unsigned DataW = LANES * 8;

  typedef enum logic [1:0] {StIdle, StBuild, StDone} state_e;

  state_e             state_q, state_d;
  logic [DataW-1:0]   bytes_q;
  logic [1:0]         len_q;
  logic               sext_q;
  logic [DataW-1:0]   acc_q;
  logic [1:0]         cnt_q;

  logic               accept;
  logic               last_lane;
  logic [DataW-1:0]   acc_sum;
  logic [DataW-1:0]   acc_final;

  assign accept    = req_valid && (state_q == StIdle);
  assign last_lane = (cnt_q == len_q);
  // Lane index times 8 gives the byte shift; cnt is 2 bits so the shift never exceeds 24.
  assign acc_sum   = acc_q | (zext_word << {cnt_q, 3'b000});

`ifdef IMM_SEQ_SIGN_EXT_EN
  // Sign-fill everything above the top used lane when the request asked for it.
  always_comb begin
    acc_final = acc_sum;
    if (sext_q) begin
      unique case (len_q)
        2'd0:    acc_final[31:8]  = {24{acc_sum[7]}};
        2'd1:    acc_final[31:16] = {16{acc_sum[15]}};
        2'd2:    acc_final[31:24] = {8{acc_sum[23]}};
        default: acc_final        = acc_sum;
      endcase
    end
  end
`else
  logic unused_sext;
  assign unused_sext = sext_q;

  // Zero-fill only: the final accumulate is the plain OR.
  always_comb begin
    acc_final = acc_sum;
  end
`endif

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = StBuild;
      StBuild: if (last_lane) state_d = StDone;
      StDone:  if (res_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the registered state; result reads 0 unless presented.
  always_comb begin
    req_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    res_valid = (state_q == StDone);
    res_data  = '0;
    zext_byte = 8'h00;
    if (state_q == StDone) begin
      res_data = acc_q;
    end
    if (state_q == StBuild) begin
      zext_byte = bytes_q[{cnt_q, 3'b000} +: 8];
    end
  end

  // Request latch, accumulator and lane counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bytes_q <= '0;
      len_q   <= 2'd0;
      sext_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= 2'd0;
    end else if (accept) begin
      bytes_q <= req_bytes;
      len_q   <= req_len;
      sext_q  <= req_sext;
      acc_q   <= '0;
      cnt_q   <= 2'd0;
    end else if (state_q == StBuild) begin
      acc_q <= last_lane ? acc_final : acc_sum;
      cnt_q <= cnt_q + 2'd1;
    end
  end

endmodule

// File: tb/tb_imm_build_sequencer.sv
// Directed bench for imm_build_sequencer. The zero-extension unit is modelled inline.
module tb_imm_build_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_bytes;
  logic [1:0]  req_len;
  logic        req_sext;
  logic [7:0]  zext_byte;
  logic [31:0] zext_word;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign zext_word = {24'h000000, zext_byte};

  imm_build_sequencer #(.LANES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_bytes (req_bytes),
    .req_len   (req_len),
    .req_sext  (req_sext),
    .zext_byte (zext_byte),
    .zext_word (zext_word),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b1; req_bytes = 32'h55AA55AA; req_len = 2'd3;
    req_sext = 1'b0; res_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (req_ready !== 1'b1) begin errors++;
      $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++;
      $display("FAIL reset_res_valid got %b want 0", res_valid); end
    checks++; if (res_data !== 32'h0) begin errors++;
      $display("FAIL reset_res_data got %h want 00000000", res_data); end
    checks++; if (zext_byte !== 8'h00) begin errors++;
      $display("FAIL reset_zext_byte got %h want 00", zext_byte); end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy got %b want 0", busy); end
    req_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL reset_no_accept busy got %b want 0", busy); end
  endtask

  task automatic test_full_word();
    logic [31:0] exp_w;
    exp_w = 32'hDEADBEEF;
    req_valid = 1'b1; req_bytes = exp_w; req_len = 2'd3; req_sext = 1'b0; res_ready = 1'b1;
    tick();  // acceptance edge
    req_valid = 1'b0; req_bytes = 32'h0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (zext_byte !== exp_w[8*i +: 8] || busy !== 1'b1 || res_valid !== 1'b0) begin
        errors++;
        $display("FAIL full_lane%0d zext=%h busy=%b rv=%b want %h 1 0",
                 i, zext_byte, busy, res_valid, exp_w[8*i +: 8]);
      end
      tick();
    end
    checks++; if (res_valid !== 1'b1 || res_data !== 32'hDEADBEEF) begin errors++;
      $display("FAIL full_result rv=%b data=%h want 1 deadbeef", res_valid, res_data); end
    checks++; if (zext_byte !== 8'h00) begin errors++;
      $display("FAIL full_done_zext got %h want 00", zext_byte); end
    tick();
    checks++; if (req_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 32'h0) begin
      errors++;
      $display("FAIL full_return rr=%b rv=%b data=%h want 1 0 0", req_ready, res_valid, res_data);
    end
  endtask

  task automatic test_sext();
    logic [31:0] exp_w;
`ifdef IMM_SEQ_SIGN_EXT_EN
    exp_w = 32'hFFFFFFA5;
`else
    exp_w = 32'h000000A5;
`endif
    req_valid = 1'b1; req_bytes = 32'h000000A5; req_len = 2'd0; req_sext = 1'b1; res_ready = 1'b1;
    tick();
    req_valid = 1'b0; req_sext = 1'b0;
    checks++; if (zext_byte !== 8'hA5 || res_valid !== 1'b0) begin errors++;
      $display("FAIL sext_lane zext=%h rv=%b want a5 0", zext_byte, res_valid); end
    tick();
    checks++; if (res_valid !== 1'b1 || res_data !== exp_w) begin errors++;
      $display("FAIL sext_result rv=%b data=%h want 1 %h", res_valid, res_data, exp_w); end
    tick();
  endtask

  task automatic test_stall();
    req_valid = 1'b1; req_bytes = 32'h12347F80; req_len = 2'd1; req_sext = 1'b0; res_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 32'h00007F80) begin errors++;
      $display("FAIL stall_result rv=%b data=%h want 1 00007f80", res_valid, res_data); end
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_bytes = 32'hCAFEF00D; req_len = 2'd3;
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_data !== 32'h00007F80 || busy !== 1'b1 || req_ready !== 1'b0)
      begin
        errors++;
        $display("FAIL stall_hold%0d rv=%b data=%h busy=%b rr=%b want 1 00007f80 1 0",
                 i, res_valid, res_data, busy, req_ready);
      end
    end
    req_valid = 1'b0; res_ready = 1'b1;
    tick();
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin errors++;
      $display("FAIL stall_release rr=%b busy=%b rv=%b want 1 0 0", req_ready, busy, res_valid);
    end
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_bytes = 32'h00000042; req_len = 2'd0; res_ready = 1'b1;
    tick(); tick();
    // Done with res_ready and a pending request: must pass through IDLE first.
    checks++; if (res_valid !== 1'b1 || res_data !== 32'h00000042) begin errors++;
      $display("FAIL b2b_first rv=%b data=%h want 1 00000042", res_valid, res_data); end
    req_bytes = 32'h00000017;
    tick();
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++;
      $display("FAIL b2b_idle busy=%b rr=%b want 0 1", busy, req_ready); end
    tick();
    req_valid = 1'b0;
    tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 32'h00000017) begin errors++;
      $display("FAIL b2b_second rv=%b data=%h want 1 00000017", res_valid, res_data); end
    tick();
  endtask

  task automatic test_reset_abort();
    bit seen_valid;
    req_valid = 1'b1; req_bytes = 32'hDEADBEEF; req_len = 2'd3; req_sext = 1'b0; res_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0 || zext_byte !== 8'h00 || res_valid !== 1'b0) begin errors++;
      $display("FAIL abort_idle busy=%b zext=%h rv=%b want 0 00 0", busy, zext_byte, res_valid);
    end
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (res_valid !== 1'b0) seen_valid = 1'b1;
    end
    checks++; if (seen_valid) begin errors++;
      $display("FAIL abort_no_result res_valid seen 1 want 0"); end
    req_valid = 1'b1; req_bytes = 32'h11223344; req_len = 2'd2;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 32'h00223344) begin errors++;
      $display("FAIL abort_next rv=%b data=%h want 1 00223344", res_valid, res_data); end
    tick();
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_sext();
    test_stall();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
